// File: rtl/adc78h90_responder.sv
// adc78h90_responder: SPI responder emulating an ADC78H90 8-channel 12-bit ADC
module adc78h90_responder #(
  parameter int RESET_CHAN = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        ncs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] ain1,
  input  logic [11:0] ain2,
  input  logic [11:0] ain3,
  input  logic [11:0] ain4,
  input  logic [11:0] ain5,
  input  logic [11:0] ain6,
  input  logic [11:0] ain7,
  input  logic [11:0] ain8,
  output logic [2:0]  chan_sel,
  output logic [15:0] ctrl_word,
  output logic        frame_done,
  output logic        frame_error
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HI} state_t;
  state_t state, state_d;
  logic [2:0] sclk_s, ncs_s;
  logic [1:0] mosi_s;
  logic [14:0] tx, tx_d, rx, rx_d;
  logic [15:0] ctrl_d;
  logic [4:0] cnt, cnt_d;
  logic [2:0] chan_d;
  logic miso_d, oe_d, done_d, err_d;
  logic [7:0][11:0] ain;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  assign ain = {ain8, ain7, ain6, ain5, ain4, ain3, ain2, ain1};
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign ncs_rise = ncs_s[1] & ~ncs_s[2];
  assign ncs_fall = ~ncs_s[1] & ncs_s[2];
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_s <= '0;
      ncs_s <= '0;
      mosi_s <= '0;
      state <= WAIT_HI;
      tx <= '0;
      rx <= '0;
      cnt <= '0;
      miso <= 1'b0;
      miso_oe <= 1'b0;
      chan_sel <= 3'(RESET_CHAN);
      ctrl_word <= '0;
      frame_done <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk};
      ncs_s <= {ncs_s[1:0], ncs};
      mosi_s <= {mosi_s[0], mosi};
      state <= state_d;
      tx <= tx_d;
      rx <= rx_d;
      cnt <= cnt_d;
      miso <= miso_d;
      miso_oe <= oe_d;
      chan_sel <= chan_d;
      ctrl_word <= ctrl_d;
      frame_done <= done_d;
      frame_error <= err_d;
    end
  end
  always_comb begin
    state_d = state;
    tx_d = tx;
    rx_d = rx;
    cnt_d = cnt;
    miso_d = miso;
    oe_d = miso_oe;
    chan_d = chan_sel;
    ctrl_d = ctrl_word;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state)
      IDLE: if (ncs_fall) begin
        tx_d = {3'd0, ain[chan_sel]};
        miso_d = 1'b0;
        oe_d = 1'b1;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (sclk_rise && cnt == 5'd15) begin
        cnt_d = 5'd16;
        ctrl_d = {rx, mosi_s[1]};
        chan_d = ctrl_d[13:11];
        done_d = 1'b1;
        miso_d = 1'b0;
        oe_d = ~ncs_s[1];
        state_d = ncs_s[1] ? IDLE : WAIT_HI;
      end else if (ncs_rise) begin
        err_d = 1'b1;
        miso_d = 1'b0;
        oe_d = 1'b0;
        state_d = IDLE;
      end else if (sclk_rise) begin
        rx_d = {rx[13:0], mosi_s[1]};
        cnt_d = cnt + 5'd1;
      end else if (sclk_fall) begin
        miso_d = tx[14];
        tx_d = {tx[13:0], 1'b0};
      end
      default: begin
        miso_d = 1'b0;
        oe_d = ncs_s[1] ? 1'b0 : miso_oe;
        state_d = ncs_s[1] ? IDLE : WAIT_HI;
      end
    endcase
  end
endmodule

// File: tb/tb_adc78h90_responder.sv
// tb_adc78h90_responder: scoreboard bench driving a clock/4 SPI host
module tb_adc78h90_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic ncs = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, frame_done, frame_error;
  logic [2:0] chan_sel;
  logic [15:0] ctrl_word;
  logic [11:0] ain [8];
  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] ctrl;
    logic [2:0]  chan;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;
  int n_exp = 0;
  logic [15:0] host_rd = '0;
  logic [11:0] exp12 [12] = '{12'h333, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555,
                              12'h666, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555};

  adc78h90_responder #(.RESET_CHAN(0)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .ncs(ncs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .ain1(ain[0]), .ain2(ain[1]), .ain3(ain[2]), .ain4(ain[3]),
    .ain5(ain[4]), .ain6(ain[5]), .ain7(ain[6]), .ain8(ain[7]),
    .chan_sel(chan_sel), .ctrl_word(ctrl_word),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic edges(input logic [15:0] cw, input int first, input int n, input bit zchk);
    for (int i = first; i < first + n; i++) begin
      mosi = (i < 16) ? cw[15-i] : 1'b1;
      step(3);
      sclk = 1'b1;
      step(1);
      if (i < 16) host_rd[15-i] = miso;
      if (zchk || i >= 16) check("miso_idle_zero", {15'd0, miso}, 16'd0);
      sclk = 1'b0;
    end
  endtask

  task automatic finish_frame();
    step(3);
    ncs = 1'b1;
    step(1);
  endtask

  task automatic frame(input logic [15:0] cw, input logic [11:0] rd, input int n);
    exp_t x;
    x.rd = {4'd0, rd};
    x.ctrl = cw;
    x.chan = cw[13:11];
    q.push_back(x);
    n_exp++;
    ncs = 1'b0;
    edges(cw, 0, n, 1'b0);
    finish_frame();
  endtask

  always @(negedge clock) begin
    if (frame_error) n_err++;
    if (frame_done) begin
      n_done++;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got ctrl %h expected no frame", ctrl_word);
      end else begin
        e = q.pop_front();
        check("miso_word", host_rd, e.rd);
        check("ctrl_word", ctrl_word, e.ctrl);
        check("chan_sel", {13'd0, chan_sel}, {13'd0, e.chan});
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) ain[i] = 12'h000;
    step(3);
    check("reset_miso", {15'd0, miso}, 16'd0);
    check("reset_miso_oe", {15'd0, miso_oe}, 16'd0);
    check("reset_chan_sel", {13'd0, chan_sel}, 16'd0);
    check("reset_ctrl_word", ctrl_word, 16'd0);
    check("reset_pulses", {14'd0, frame_done, frame_error}, 16'd0);
    reset = 1'b0;
    step(4);
    ain[0] = 12'hABC;
    frame(16'h0800, 12'hABC, 16);
    ain[1] = 12'h123;
    frame(16'h1000, 12'h123, 16);
    ain = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666, 12'h777, 12'h888};
    for (int i = 0; i < 12; i++) frame({2'b00, 3'(i % 6), 11'd0}, exp12[i], 16);
    ncs = 1'b0;
    edges(16'h3800, 0, 7, 1'b0);
    finish_frame();
    step(4);
    check("abort_error_count", 16'(n_err), 16'd1);
    check("abort_chan_kept", {13'd0, chan_sel}, 16'd5);
    check("abort_ctrl_kept", ctrl_word, 16'h2800);
    frame(16'h0000, 12'h666, 16);
    ncs = 1'b0;
    edges(16'hFFFF, 0, 5, 1'b0);
    check("midframe_miso_oe", {15'd0, miso_oe}, 16'd1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("midreset_chan_sel", {13'd0, chan_sel}, 16'd0);
    check("midreset_ctrl_word", ctrl_word, 16'd0);
    check("midreset_miso_oe", {15'd0, miso_oe}, 16'd0);
    begin
      int d0;
      d0 = n_done;
      edges(16'hFFFF, 5, 11, 1'b1);
      step(4);
      check("midreset_no_done", 16'(n_done), 16'(d0));
    end
    finish_frame();
    frame(16'h2000, 12'h111, 16);
    frame(16'hA5C3, 12'h555, 20);
    step(10);
    check("pending_frames", 16'(q.size()), 16'd0);
    check("done_count", 16'(n_done), 16'(n_exp));
    check("error_count", 16'(n_err), 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adc78h90_responder.md
Name: adc78h90_responder

Overview:
- Synthesizable SPI responder that emulates an ADC78H90 8-channel, 12-bit ADC, for loopback self-test and bench use.
- Samples host-driven sclk/ncs/mosi in the local clock domain and decodes the channel address in each 16-bit control word.
- Shifts out the 12-bit value of the channel addressed in the *previous* frame, matching device semantics.
- Channel values come from parallel inputs ain1..ain8 (internal test patterns or captured telemetry).

Parameters:
- RESET_CHAN, 0, channel converted in the first frame after reset (0..7 maps to ain1..ain8).

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sclk  in  1  host SPI clock, asynchronous; double-synchronized internally
- ncs  in  1  host chip select, active low, asynchronous; double-synchronized
- mosi  in  1  host data, asynchronous; double-synchronized
- miso  out  1  serial data to host
- miso_oe  out  1  1 while a frame is active; host-facing tristate enable
- ain1..ain8  in  12 each  channel values; ain1 is address 0, ain8 is address 7
- chan_sel  out  3  address currently selected for conversion
- ctrl_word  out  16  last complete control word received, MSB first
- frame_done  out  1  one-clock pulse when the 16th rising sclk edge is accepted
- frame_error  out  1  one-clock pulse when ncs rises before 16 rising edges

Behaviour:
- Synchronization:
  - sclk, ncs and mosi each pass through 2 flip-flops plus a third history flip-flop for edge detection.
  - Edge detection compares the second and third stages.
  - Latency from a pin transition to an internal event is 2 clocks.
- Reset values:
  - miso=0, miso_oe=0, chan_sel=RESET_CHAN, ctrl_word=0, frame_done=0, frame_error=0.
  - Bit counter=0, shift registers=0, state=WAIT_HI.
- States:
  - IDLE: waits for a synchronized ncs falling edge. On that edge:
    - latch sample = {4'b0, ain[chan_sel]} into the 16-bit output shift register;
    - miso <= 0 (bit 15);
    - miso_oe <= 1;
    - counter <= 0;
    - go to SHIFT.
  - SHIFT, on a synchronized sclk rising edge:
    - shift mosi (sync stage 2) into rx_shift, MSB first;
    - counter <= counter + 1;
    - if the counter reaches 16: ctrl_word <= received word, chan_sel <= received bits [13:11], pulse frame_done, go to WAIT_HI.
  - SHIFT, on a synchronized sclk falling edge: shift the output register left and set miso to the new MSB. Bits 15..12 are always 0 and bits 11..0 are the sample, MSB first.
  - SHIFT, on a synchronized ncs rising edge: pulse frame_error, leave chan_sel and ctrl_word unchanged, miso <= 0, miso_oe <= 0, go to IDLE.
  - WAIT_HI:
    - extra sclk edges are ignored and miso stays 0;
    - when synchronized ncs is 1, miso_oe <= 0 and go to IDLE;
    - an ncs fall is not accepted as a new frame until ncs has been seen high.
- MISO timing:
  - miso is registered and updates exactly 3 clocks after the sclk falling edge at the pin (2 sync + 1 output register).
  - Host requirement: sclk low time ≥3 clocks, and the host samples miso ≥1 clock after its sclk rise. A clock/4 host with 3-clock low time meets this.
- Frame separation: ncs may be high for as little as 1 clock between frames. The synchronizer preserves a 1-clock high pulse, so back-to-back frames must be accepted.
- Snapshot timing: ain values are sampled only at frame start. Changes to ain during a frame do not affect that frame.
- Simultaneous events:
  - ncs rise in the same clock as the 16th rising edge: the rising edge takes priority. The frame completes with frame_done, then the state goes to IDLE in that clock; no frame_error.
  - ncs fall in the same clock as an sclk edge in IDLE: only the frame start is taken; the sclk edge is ignored.
- Reset mid-frame: all outputs and state return to reset values. If the host is mid-frame, the remaining edges are ignored until ncs returns high.
- Only address bits [13:11] are decoded. All other control bits are stored in ctrl_word and otherwise ignored.

Test Plan:
- Reset, then drive ain1=12'hABC and run one frame with control word 16'h0800: miso sequence reads 16'h0ABC, chan_sel=1 after frame_done, ctrl_word=16'h0800.
- With ain2=12'h123, run a second frame with control word 16'h1000: host reads 16'h0123 (previous address 1 → ain2), chan_sel becomes 2.
- Use a clock/4 host with 3-clock sclk low and 1-clock ncs-high gaps, cycling addresses 0..5 for 12 frames, with ain(n)=n*12'h111: every word equals the previously addressed channel and there are no missed frames.
- Raise ncs after 7 rising edges of a frame carrying 16'h3800: frame_error pulses once, chan_sel and ctrl_word are unchanged, and the next full frame outputs the old channel.
- Assert reset after 5 edges with ncs held low, then send 11 more edges: no frame_done, miso=0. After ncs goes high and a new 16'h2000 frame runs, the output uses RESET_CHAN data and chan_sel=4.
- Send 20 sclk edges in one ncs-low window: frame_done occurs at edge 16, the extra edges are ignored, miso=0 after bit 0, and ctrl_word holds the first 16 bits.
